send_pkt_mux_rr: RTL
====================

// Module: send_pkt_mux_rr
//
// PURPOSE
//  - N-input round-robin arbiter/mux for send_pkt_struct-style records, with a 2-entry skid buffer on the output.
//  - Merges NUM_SRCS valid/ready producers (e.g. RX-ack, timer-retransmit and app-send paths) onto one send-packet pipe.
//  - Tags each output beat with the winning source id.
//  - Upstream ready depends only on local buffer occupancy, so there is no combinational dst->src ready path.
//
// PARAMETERS
//  NUM_SRCS   4          number of input sources, >=1
//  DATA_W     SEND_PKT_STRUCT_W   payload width per source
//  SRC_ID_W   (NUM_SRCS>1)?$clog2(NUM_SRCS):1   width of source tag (derived)
//  STATS_W    32         grant counter width (SEND_PKT_MUX_STATS_EN only)
//
// PORTS
//  clk              in   1                  clock
//  rst              in   1                  synchronous, active-high reset
//  src_mux_val      in   NUM_SRCS           per-source valid; bit i = source i
//  src_mux_data     in   NUM_SRCS*DATA_W    flat payloads; source i at [i*DATA_W +: DATA_W]
//  mux_src_rdy      out  NUM_SRCS           per-source ready (one-hot or zero)
//  mux_dst_val      out  1                  output valid (head of skid buffer)
//  mux_dst_data     out  DATA_W             output payload
//  mux_dst_src_id   out  SRC_ID_W           source index of the head beat
//  dst_mux_rdy      in   1                  downstream ready
//  stats_clr        in   1                  clear grant counters (STATS_EN only)
//  grant_cnt        out  NUM_SRCS*STATS_W   per-source accepted-beat counts (STATS_EN only)
//
// BEHAVIOUR
//  - Handshakes: input transfer on src_mux_val[i] & mux_src_rdy[i]; output transfer on mux_dst_val & dst_mux_rdy.
//    A source holds val/data stable until accepted.
//  - Arbitration: combinational, same cycle.
//    - Grant the first valid source scanning last_grant+1, +2, ... with wrap modulo NUM_SRCS.
//    - At most one mux_src_rdy bit is high; it is the granted bit AND (occ<2).
//    - With no valid sources, mux_src_rdy = 0.
//  - last_grant register:
//    - Updates to the granted index only on an accepted input transfer.
//    - With no transfer, it holds, so an unaccepted requester keeps priority.
//    - Reset value NUM_SRCS-1, so source 0 wins first.
//  - Skid buffer:
//    - 2 entries, each entry {data, src_id}; occupancy occ in 0..2.
//    - push = input transfer; pop = output transfer; occ_next = occ + push - pop.
//    - Push and pop in the same cycle are allowed at occ=1.
//    - At occ=2, push is impossible because rdy=0; a pop that cycle makes rdy available next cycle.
//    - FIFO order is preserved: head entry drives mux_dst_data and mux_dst_src_id.
//  - Latency: input accept in cycle t -> mux_dst_val=1 in cycle t+1 (registered). No bypass.
//  - Throughput: 1 beat/cycle sustained while dst_mux_rdy=1.
//  - Fairness: with all NUM_SRCS valid continuously, grants cycle 0,1,..,N-1,0,...
//  - mux_dst_val = (occ!=0). mux_dst_data and mux_dst_src_id are don't-care when val=0; they are not required to be zeroed.
//  - Reset (synchronous, any time):
//    - occ=0, mux_dst_val=0, mux_src_rdy=0, last_grant=NUM_SRCS-1, grant_cnt=0.
//    - In-flight beats are dropped.
//    - Reset takes priority over same-cycle push/pop.
//  - NUM_SRCS=1: acts as a 2-deep registered skid buffer; mux_dst_src_id is always 0.
//
// CONFIGURATION
//  SEND_PKT_MUX_STATS_EN defined:
//    - grant_cnt[i] increments on each input transfer from source i.
//    - Counters saturate at all-ones (no wrap).
//    - stats_clr=1 sets all counters to 0 that cycle; clear beats a same-cycle increment.
//  SEND_PKT_MUX_STATS_EN undefined:
//    - stats_clr and grant_cnt ports are absent.
//    - No counter logic; datapath behaviour identical.
//
// TESTING
//  1. Reset, then src0 valid with data 0xA, dst_rdy=1
//     -> rdy[0]=1 cycle 0; out val=1, data=0xA, id=0 cycle 1.
//  2. NUM_SRCS=4, all valid for 8 cycles, dst_rdy=1
//     -> ids 0,1,2,3,0,1,2,3 on the output, one per cycle.
//  3. dst_rdy=0, srcs 1,2 valid
//     -> two beats accepted (ids 1,2), then rdy=0 all.
//     -> Raise dst_rdy: ids 1,2 out in order, then src1 re-granted.
//  4. src2 valid alone while buffer full
//     -> after one pop, rdy[2]=1 next cycle; last_grant stays unchanged until that accept.
//  5. Assert rst with occ=2 mid-stream -> next cycle val=0, occ=0; first grant after reset is src0.
//  6. STATS_EN, STATS_W=4, src3 accepted 20 times -> grant_cnt[3]=15 (saturated).
//     -> stats_clr with a same-cycle accept gives 0.

Source files
------------

// File: rtl/send_pkt_mux_rr_if.sv
// Source-side and destination-side handshake bundle for send_pkt_mux_rr.
// The mux binds to the slave modport; the producers/consumer side binds to master.
interface send_pkt_mux_rr_if #(
  parameter int NUM_SRCS = 4,
  parameter int DATA_W   = 64
);
  localparam int SRC_ID_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

  logic [NUM_SRCS-1:0]        src_mux_val;
  logic [NUM_SRCS*DATA_W-1:0] src_mux_data;
  logic [NUM_SRCS-1:0]        mux_src_rdy;
  logic                       mux_dst_val;
  logic [DATA_W-1:0]          mux_dst_data;
  logic [SRC_ID_W-1:0]        mux_dst_src_id;
  logic                       dst_mux_rdy;

  modport master (
    output src_mux_val, src_mux_data, dst_mux_rdy,
    input  mux_src_rdy, mux_dst_val, mux_dst_data, mux_dst_src_id
  );

  modport slave (
    input  src_mux_val, src_mux_data, dst_mux_rdy,
    output mux_src_rdy, mux_dst_val, mux_dst_data, mux_dst_src_id
  );
endinterface

// File: rtl/send_pkt_mux_rr.sv
// Round-robin N:1 send-packet mux with a 2-entry output skid buffer and source tagging.
// Optional per-source grant counters when SEND_PKT_MUX_STATS_EN is defined.
module send_pkt_mux_rr #(
  parameter int NUM_SRCS = 4,
  parameter int DATA_W   = 64
`ifdef SEND_PKT_MUX_STATS_EN
  , parameter int STATS_W = 32
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef SEND_PKT_MUX_STATS_EN
  input  logic                       stats_clr,
  output logic [NUM_SRCS*STATS_W-1:0] grant_cnt,
`endif
  send_pkt_mux_rr_if.slave           bus
);
  localparam int SRC_ID_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

  logic [1:0]          occ_q, occ_d;
  logic [SRC_ID_W-1:0] last_grant_q, last_grant_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   data_mem_q [2];
  logic [DATA_W-1:0]   data_mem_d [2];
  logic [SRC_ID_W-1:0] id_mem_q [2];
  logic [SRC_ID_W-1:0] id_mem_d [2];

  logic [SRC_ID_W-1:0] cand_idx [NUM_SRCS];
  logic                grant_vld;
  logic [SRC_ID_W-1:0] grant_idx;
  logic [NUM_SRCS-1:0] src_rdy;
  logic                push;
  logic                pop;

  // Candidate k is the (k+1)-th source after the last accepted one, wrapping.
  generate
    for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_cand
      assign cand_idx[gi] = SRC_ID_W'((int'(last_grant_q) + gi + 1) % NUM_SRCS);
    end
  endgenerate

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      if (!grant_vld && bus.src_mux_val[cand_idx[k]]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  // Ready depends only on occupancy, never on dst_mux_rdy; rst blocks a doomed accept.
  always_comb begin
    src_rdy = '0;
    if (grant_vld && (occ_q != 2'd2) && !rst) begin
      src_rdy[grant_idx] = 1'b1;
    end
  end

  assign push = |(bus.src_mux_val & src_rdy);
  assign pop  = bus.mux_dst_val & bus.dst_mux_rdy;

  always_comb begin
    occ_d        = occ_q + {1'b0, push} - {1'b0, pop};
    last_grant_d = push ? grant_idx : last_grant_q;
    rd_ptr_d     = pop  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d     = push ? ~wr_ptr_q : wr_ptr_q;
    data_mem_d   = data_mem_q;
    id_mem_d     = id_mem_q;
    if (push) begin
      data_mem_d[wr_ptr_q] = bus.src_mux_data[grant_idx*DATA_W +: DATA_W];
      id_mem_d[wr_ptr_q]   = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q        <= '0;
      last_grant_q <= SRC_ID_W'(NUM_SRCS - 1);
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      last_grant_q <= last_grant_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    data_mem_q <= data_mem_d;
    id_mem_q   <= id_mem_d;
  end

  assign bus.mux_src_rdy    = src_rdy;
  assign bus.mux_dst_val    = (occ_q != 2'd0);
  assign bus.mux_dst_data   = data_mem_q[rd_ptr_q];
  assign bus.mux_dst_src_id = id_mem_q[rd_ptr_q];

`ifdef SEND_PKT_MUX_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_stats
      logic [STATS_W-1:0] cnt_q, cnt_d;

      // Clear wins over a same-cycle increment; counters stick at all-ones.
      always_comb begin
        cnt_d = cnt_q;
        if (stats_clr) begin
          cnt_d = '0;
        end else if (push && (grant_idx == SRC_ID_W'(gi)) && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign grant_cnt[gi*STATS_W +: STATS_W] = cnt_q;
    end
  endgenerate
`endif
endmodule
